// File: rtl/hilo_sequencer.sv
// hilo_sequencer
//   Iterative multiply/divide controller owning the architectural HI/LO pair.
//   MULT/MULTU run a 32-step shift-add multiply. DIV/DIVU run a 32-step
//   restoring divide on operand magnitudes, followed by a sign fix-up cycle.
//   MTHI/MTLO are serviced while idle. EX is stalled whenever it touches HI/LO
//   or issues another mult/div while an operation is in flight.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      EX holds a mult/div instruction
//   op         0 MULTU, 1 MULT, 2 DIVU, 3 DIV
//   a, b       rs / rt operands (dividend a, divisor b)
//   hilo_read  EX holds MFHI/MFLO
//   mt_en      EX holds MTHI/MTLO; mt_sel 0 = LO, 1 = HI; mt_data is the value
//   hi, lo     architectural HI/LO
//   busy       operation in flight
//   stall      hold EX this cycle
//   done       one-cycle pulse after HI/LO were written by an operation
//   div_zero   current/last operation is a divide by zero (sticky until start)
module hilo_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_read,
  input  logic             mt_en,
  input  logic             mt_sel,
  input  logic [WIDTH-1:0] mt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

  localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

  state_t state, state_nxt;

  logic [4:0]         cnt;
  logic [1:0]         op_q;
  logic               neg_a;    // dividend/multiplicand sign, signed ops only
  logic               neg_b;    // divisor/multiplier sign, signed ops only
  logic [WIDTH-1:0]   arg_b;    // multiplicand (mult) or divisor (div) magnitude
  logic [WIDTH-1:0]   a_raw;    // dividend as presented, returned on divide by zero
  logic [2*WIDTH-1:0] acc;      // {P_hi, multiplier} or {remainder, quotient}

  // Operand magnitudes at issue; unsigned ops pass raw values.
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sgn_a = op[0] & a[WIDTH-1];
  assign sgn_b = op[0] & b[WIDTH-1];
  assign mag_a = sgn_a ? -a : a;
  assign mag_b = sgn_b ? -b : b;

  // One multiply step: conditional add into the upper half with carry-out,
  // then shift the whole accumulator right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? arg_b : '0)};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // One restoring-divide step on the left-shifted register. The extra top bit
  // of the trial difference is its sign.
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] div_next;

  assign div_trial = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, arg_b};
  assign div_next  = div_trial[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign fix-up of the finished iteration result.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign prod_fix = (neg_a ^ neg_b) ? -acc : acc;
  assign quo_fix  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch cannot be inferred.
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (op_q[1]) begin
      if (div_zero) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is assigned with non-blocking <= so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST_ITER) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and architectural registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the iteration datapath is reset along with HI/LO; it is a handful
      // of flops, not a memory, and a clean reset keeps an aborted operation
      // from leaving stale values behind.
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      op_q     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      arg_b    <= '0;
      a_raw    <= '0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // A simultaneous MT is not a legal encoding; the start wins.
            op_q     <= op;
            neg_a    <= sgn_a;
            neg_b    <= sgn_b;
            a_raw    <= a;
            cnt      <= '0;
            div_zero <= op[1] & (b == '0);
            if (op[1]) begin
              acc   <= {{WIDTH{1'b0}}, mag_a};
              arg_b <= mag_b;
            end else begin
              acc   <= {{WIDTH{1'b0}}, mag_b};
              arg_b <= mag_a;
            end
          end else if (mt_en) begin
            if (mt_sel) hi <= mt_data;
            else        lo <= mt_data;
          end
        end
        RUN: begin
          acc <= op_q[1] ? div_next : mul_next;
          cnt <= cnt + 5'd1;
        end
        FIXUP: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign stall = busy & (start | hilo_read | mt_en);

endmodule

// File: tb/tb_hilo_sequencer.sv
// tb_hilo_sequencer
//   Randomised self-checking bench for hilo_sequencer. The driver issues
//   operations and pushes the reference result (computed with plain 64-bit
//   arithmetic on operand values) into a scoreboard queue; an independent
//   monitor pops and compares whenever done pulses, including the cycle the
//   result was due.
module tb_hilo_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0;
  logic        hilo_read = 1'b0;
  logic        mt_en = 1'b0;
  logic        mt_sel = 1'b0;
  logic [31:0] mt_data = '0;
  logic [31:0] hi, lo;
  logic        busy, stall, done, div_zero;

  hilo_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .hilo_read (hilo_read),
    .mt_en     (mt_en),
    .mt_sel    (mt_sel),
    .mt_data   (mt_data),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
  } exp_t;

  exp_t sb[$];

  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: architectural meaning of each op.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    longint      sx, sy, p;
    logic [63:0] up;
    logic [31:0] ma, mb, q, rm;
    r.dz  = 1'b0;
    r.due = 0;
    case (o)
      2'd0: begin
        up   = {32'd0, x} * {32'd0, y};
        r.hi = up[63:32];
        r.lo = up[31:0];
      end
      2'd1: begin
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        p    = sx * sy;
        up   = 64'(p);
        r.hi = up[63:32];
        r.lo = up[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          r.dz = 1'b1;
          r.lo = 32'hFFFF_FFFF;
          r.hi = x;
        end else begin
          ma = (o == 2'd3 && x[31]) ? (32'd0 - x) : x;
          mb = (o == 2'd3 && y[31]) ? (32'd0 - y) : y;
          q  = ma / mb;
          rm = ma % mb;
          if (o == 2'd3 && (x[31] != y[31])) q  = 32'd0 - q;
          if (o == 2'd3 && x[31])            rm = 32'd0 - rm;
          r.lo = q;
          r.hi = rm;
        end
      end
    endcase
    return r;
  endfunction

  // Monitor: compares every completed operation against the scoreboard.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      if (prev_done) check("done_width", 64'(done & prev_done), 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_hi",       64'(hi),       64'(e.hi));
        check("res_lo",       64'(lo),       64'(e.lo));
        check("res_div_zero", 64'(div_zero), 64'(e.dz));
        check("res_latency",  64'(cyc),      64'(e.due));
      end
    end
    prev_done <= done;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  // mode: 0 quiet, 1 hold hilo_read + spurious starts, 2 MTLO during busy,
  // 3 random start/read/MT noise while busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int mode);
    exp_t e;
    int   n;
    bit   seen;
    wait_idle();
    start     = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    mt_en     = 1'b0;
    hilo_read = (mode == 1);
    e     = model(o, x, y);
    e.due = cyc + 1 + 33;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    n     = 0;
    seen  = 1'b0;
    while (n < 40 && !seen) begin
      if (busy) begin
        case (mode)
          1: begin start = 1'b1; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom; end
          2: begin mt_en = 1'b1; mt_sel = 1'b0; mt_data = $urandom; end
          3: begin
            start     = 1'($urandom_range(0, 1));
            op        = 2'($urandom_range(0, 3));
            hilo_read = 1'($urandom_range(0, 1));
            mt_en     = 1'($urandom_range(0, 1));
            mt_sel    = 1'($urandom_range(0, 1));
            mt_data   = $urandom;
          end
          default: ;
        endcase
      end else begin
        start = 1'b0;
        mt_en = 1'b0;
        if (mode == 3) hilo_read = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check("stall_done_cycle", 64'(stall), 64'd0);
        check("busy_done_cycle",  64'(busy),  64'd0);
      end else begin
        check("busy_run",  64'(busy),  64'd1);
        check("stall_run", 64'(stall), 64'(start | hilo_read | mt_en));
        check("hi_hold",   64'(hi),    64'(model_hi));
        check("lo_hold",   64'(lo),    64'(model_lo));
        @(posedge clk); #1;
        n++;
      end
    end
    if (!seen) check("done_timeout", 64'(seen), 64'd1);
    model_hi  = e.hi;
    model_lo  = e.lo;
    hilo_read = 1'b0;
    start     = 1'b0;
    mt_en     = 1'b0;
    if (mode == 1) begin
      // The spurious starts must not have been queued up.
      @(posedge clk); #1;
      check("no_ghost_start", 64'(busy), 64'd0);
    end
  endtask

  task automatic mt_write(input logic sel, input logic [31:0] data);
    wait_idle();
    mt_en   = 1'b1;
    mt_sel  = sel;
    mt_data = data;
    @(posedge clk); #1;
    mt_en = 1'b0;
    if (sel) model_hi = data;
    else     model_lo = data;
    @(negedge clk);
    check("mt_hi", 64'(hi), 64'(model_hi));
    check("mt_lo", 64'(lo), 64'(model_lo));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    // Reset state.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    hilo_read = 1'b1;
    @(negedge clk);
    check("rst_hi",       64'(hi),       64'd0);
    check("rst_lo",       64'(lo),       64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_done",     64'(done),     64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("idle_read_stall", 64'(stall), 64'd0);
    hilo_read = 1'b0;

    // Directed vectors.
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(lo), 64'h0000_0001);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd5, 0);
    check("mult_neg_lo", 64'(lo), 64'hFFFF_FFF1);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(2'd2, 32'h0000_0064, 32'd0, 0);
    check("divu_zero_flag", 64'(div_zero), 64'd1);
    run_op(2'd0, 32'd2, 32'd3, 0);
    check("div_zero_cleared", 64'(div_zero), 64'd0);
    run_op(2'd3, 32'hFFFF_FFFB, 32'd0, 0);   // signed divide by zero
    check("div_zero_hi_raw", 64'(hi), 64'hFFFF_FFFB);

    // Stall with read held and spurious starts.
    run_op(2'd1, 32'h1234_5678, 32'h8765_4321, 1);

    // MTHI in idle, then MTLO during busy.
    mt_write(1'b1, 32'h0000_1234);
    run_op(2'd0, 32'h0001_0000, 32'h0000_0300, 2);

    // Reset mid-operation: no partial result, no done.
    wait_idle();
    start = 1'b1; op = 2'd1; a = 32'h7654_3210; b = 32'hF000_0001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_hi",   64'(hi),    64'd0);
    check("abort_lo",   64'(lo),    64'd0);
    check("abort_busy", 64'(busy),  64'd0);
    check("abort_done", 64'(done),  64'd0);
    model_hi = '0;
    model_lo = '0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (40) @(posedge clk);   // the monitor flags any stray done
    #1;
    check("abort_idle", 64'(busy), 64'd0);

    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(hi), 64'h0000_0000);

    // Randomised operations, back-to-back in most cases.
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 9));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
        default: rb = $urandom;
      endcase
      run_op(2'($urandom_range(0, 3)), ra, rb, $urandom_range(0, 3));
      if (i % 7 == 3) mt_write(1'($urandom_range(0, 1)), $urandom);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_sequencer.md
# hilo_sequencer

Iterative multiply/divide controller for the HI/LO resource of the execute stage. It accepts MULT/MULTU/DIV/DIVU operations from EX and sequences a 32-iteration shift-add multiply or restoring divide with sign fix-up. It owns the HI and LO registers, services MTHI/MTLO writes, and raises a stall to EX whenever an instruction touches HI/LO while an operation is in flight.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is required to work.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; one clock, asynchronous and active-low (rst=0 resets).
- start  input  1  EX holds a mult/div instruction this cycle.
- op  input  2  operation: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV.
- a, b  input  WIDTH  operands: rs and rt; dividend a, divisor b.
- hilo_read  input  1  EX holds MFHI/MFLO this cycle.
- mt_en  input  1  EX holds MTHI/MTLO this cycle.
- mt_sel  input  1  0 writes LO, 1 writes HI.
- mt_data  input  WIDTH  data for MTHI/MTLO.
- hi, lo  output  WIDTH  architectural HI/LO register values.
- busy  output  1  operation in flight.
- stall  output  1  hold EX; the instruction re-presents next cycle.
- done  output  1  one-cycle pulse; HI/LO were just updated by an operation.
- div_zero  output  1  last completed operation was a divide by zero; sticky until next start.

## Operation
- States: IDLE, RUN, FIXUP.
- IDLE with start=1: latch op and the operand signs (signed ops only). Load |a| and |b|; unsigned ops load the raw values. Clear the 5-bit iteration counter. Set div_zero = (op[1] & b==0). Go to RUN.
- RUN multiply: 64-bit accumulator {P_hi, multiplier}. Each cycle, if multiplier LSB=1 add the multiplicand into P_hi with 33-bit carry, then shift the whole accumulator right 1.
- RUN divide: 64-bit remainder:quotient register. Each cycle, shift left 1 and trial-subtract the divisor from the upper 33 bits. If the result is non-negative, keep it and set quotient bit 0 = 1.
- RUN leaves after counter reaches 31, i.e. 32 iterations, then goes to FIXUP.
- FIXUP, signed multiply: negate the 64-bit product if the operand signs differ.
- FIXUP, signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- FIXUP writes LO=low/quotient and HI=high/remainder, then goes to IDLE.
- Divide by zero, signed or unsigned: the iterations still run. Result is forced to LO=32'hFFFFFFFF, HI=a exactly as presented (unmodified).
- 0x80000000 / -1 (DIV): the absolute-value path yields LO=0x80000000, HI=0. This needs no special case.
- mt_en in IDLE without start: writes the selected register on the next edge; the other register is unchanged.
- start and mt_en together in IDLE: start wins and the MT is dropped (not a legal encoding).
- stall = busy & (start | hilo_read | mt_en). start, MT and reads during busy have no effect other than stall.
- hilo_read in IDLE: no stall; EX reads hi/lo directly.

## Timing
- Reset values: state IDLE, hi=0, lo=0, busy=0, stall=0, done=0, div_zero=0, counter=0.
- Edge E0 samples start in IDLE; busy=1 from E0.
- Edges E1..E32 perform the iterations; E32 enters FIXUP.
- E33 updates hi/lo, clears busy and sets done for exactly one cycle (E33..E34).
- Start-to-result latency is 33 cycles. A back-to-back start is accepted at E33 (busy=0 in the done cycle).
- hilo_read in the done cycle sees new values with stall=0.
- stall is combinational from busy and the inputs; it is never asserted in IDLE.
- Reset asserted mid-operation aborts immediately. All outputs return to reset values, and no partial result reaches hi/lo.
- hi/lo change only at FIXUP→IDLE, on an MT edge, or on reset.

## Test plan
- MULTU a=FFFFFFFF b=FFFFFFFF -> after 33 edges hi=FFFFFFFE, lo=00000001, done pulses 1 cycle, busy low.
- MULT a=FFFFFFFD(-3) b=5 -> hi=FFFFFFFF, lo=FFFFFFF1; DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=00000064 b=0 -> lo=FFFFFFFF, hi=00000064, div_zero=1. Next MULTU 2*3 -> div_zero=0, lo=6, hi=0.
- During busy, hold hilo_read=1 and also pulse start with different operands -> stall=1 every busy cycle, and stall=0 in the done cycle. The result is from the first op only, and the second start is not accepted until re-presented in IDLE.
- MTHI 00001234 in IDLE -> hi=00001234 next edge, lo unchanged. MTLO during busy -> stall=1, lo unchanged until the op completes.
- Start MULT, drive rst=0 at cycle 10 -> hi=lo=0, busy=0, done never pulses. After release, DIV 0x80000000 / FFFFFFFF -> lo=80000000, hi=0.
